kavach_exec_monitor_mc: RTL and testbench

Multi-channel successor to the single-core execution monitor: observes `NUM_CH` processor harts in parallel and detects per-hart control-flow jumps, privilege escalation, out-of-bounds memory access and flush bursts. Detected events are coalesced per channel and arbitrated round-robin into an event FIFO. A threat classifier drains that FIFO over a valid/ready handshake. The block also keeps per-channel sticky flags and a global severity level.

---
 rtl/kavach_exec_monitor_mc.sv | 224 ++++++++++++++++++++++
 tb/tb_kavach_exec_monitor_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/kavach_exec_monitor_mc.sv
// Multi-hart execution monitor: per-channel anomaly detection, coalescing pending
// entries, round-robin event FIFO, sticky flags and severity. Optional macro: KAVACH_PC_BOUNDS_EN.
module kavach_exec_monitor_mc #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned PRIV_WIDTH   = 2,
  parameter logic [PC_WIDTH-1:0] PC_JUMP_THRESH = PC_WIDTH'(32'h0000_FFFF),
  parameter logic [PC_WIDTH-1:0] MEM_BASE       = PC_WIDTH'(32'h2000_0000),
  parameter logic [PC_WIDTH-1:0] MEM_TOP        = PC_WIDTH'(32'h3FFF_FFFF),
  parameter int unsigned FLUSH_WIN    = 64,
  parameter int unsigned FLUSH_THRESH = 8,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH*PC_WIDTH-1:0]     ch_pc,
  input  logic [NUM_CH*PC_WIDTH-1:0]     ch_pc_prev,
  input  logic [NUM_CH*PRIV_WIDTH-1:0]   ch_priv,
  input  logic [NUM_CH-1:0]              ch_exception,
  input  logic [NUM_CH-1:0]              ch_mem_access,
  input  logic [NUM_CH*PC_WIDTH-1:0]     ch_mem_addr,
  input  logic [NUM_CH-1:0]              ch_flush,
  input  logic [NUM_CH-1:0]              ch_mask,
  input  logic [NUM_CH-1:0]              clear_sticky,
`ifdef KAVACH_PC_BOUNDS_EN
  input  logic [PC_WIDTH-1:0]            valid_pc_base,
  input  logic [PC_WIDTH-1:0]            valid_pc_top,
`endif
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [3:0]                     evt_ch,
  output logic [3:0]                     evt_type,
  output logic [PC_WIDTH-1:0]            evt_pc,
  output logic [NUM_CH*4-1:0]            sticky,
  output logic                           any_anomaly,
  output logic [1:0]                     severity,
  output logic [7:0]                     coalesce_cnt
);

  localparam int unsigned CH_W  = 4;
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned TMR_W = (FLUSH_WIN > 1) ? $clog2(FLUSH_WIN) : 1;
  localparam int unsigned FC_W  = $clog2(FLUSH_THRESH + 1);

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [3:0]          typ;
    logic [PC_WIDTH-1:0] pc;
  } evt_t;

  logic [NUM_CH-1:0][3:0]            det_c;
  logic [NUM_CH-1:0]                 pend_vld_q, pend_vld_d;
  logic [NUM_CH-1:0][3:0]            pend_typ_q, pend_typ_d;
  logic [NUM_CH-1:0][PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
  logic [NUM_CH-1:0][PRIV_WIDTH-1:0] priv_prev_q;
  logic [NUM_CH-1:0][FC_W-1:0]       flush_cnt_q;
  logic [TMR_W-1:0]                  timer_q;
  logic                              timer_wrap_c;
  logic [CH_W-1:0]                   rr_q;
  logic [NUM_CH*4-1:0]               sticky_q, sticky_d;
  logic [1:0]                        sev_d;
  logic [7:0]                        coal_q, coal_d;
  logic [4:0]                        n_coal;
  logic [8:0]                        coal_sum;
  evt_t                              mem_q [FIFO_DEPTH];
  logic [AW-1:0]                     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              evt_valid_q, any_q;
  logic [1:0]                        sev_q;
  logic                              pop_c, full_c, gnt_vld_c;
  logic [CH_W-1:0]                   gnt_idx_c;
  evt_t                              gnt_evt_c;
  int unsigned                       best_off, off;

  assign timer_wrap_c = (timer_q == TMR_W'(FLUSH_WIN - 1));

  // Per-channel combinational detection on the sampled inputs
  for (genvar g = 0; g < NUM_CH; g++) begin : g_det
    logic [PC_WIDTH-1:0]   pc, pc_prev, diff, addr;
    logic [PRIV_WIDTH-1:0] priv;
    logic                  bounds_hit, jump_hit, priv_hit, oob_hit, flush_hit;
    assign pc      = ch_pc[g*PC_WIDTH +: PC_WIDTH];
    assign pc_prev = ch_pc_prev[g*PC_WIDTH +: PC_WIDTH];
    assign addr    = ch_mem_addr[g*PC_WIDTH +: PC_WIDTH];
    assign priv    = ch_priv[g*PRIV_WIDTH +: PRIV_WIDTH];
    assign diff    = (pc >= pc_prev) ? (pc - pc_prev) : (pc_prev - pc);
`ifdef KAVACH_PC_BOUNDS_EN
    assign bounds_hit = (pc < valid_pc_base) || (pc > valid_pc_top);
`else
    assign bounds_hit = 1'b0;
`endif
    assign jump_hit  = ch_valid[g] && ((diff > PC_JUMP_THRESH) || bounds_hit);
    assign priv_hit  = ch_valid[g] && !ch_exception[g] && (priv > priv_prev_q[g]);
    assign oob_hit   = ch_valid[g] && ch_mem_access[g] && ((addr < MEM_BASE) || (addr > MEM_TOP));
    // Fires only on the flush that brings the window count up to the threshold
    assign flush_hit = ch_flush[g] && (flush_cnt_q[g] == FC_W'(FLUSH_THRESH - 1));
    assign det_c[g]  = ch_mask[g] ? 4'b0000 : {flush_hit, priv_hit, oob_hit, jump_hit};
  end

  assign pop_c  = evt_valid_q && evt_ready;
  assign full_c = (cnt_q == CNT_W'(FIFO_DEPTH));

  // Round-robin grant: smallest rotated offset from rr_q wins
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    gnt_evt_c = '0;
    best_off  = NUM_CH;
    off       = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      off = (32'(c) + NUM_CH - 32'(rr_q)) % NUM_CH;
      if (pend_vld_q[c] && (off < best_off)) begin
        best_off  = off;
        gnt_vld_c = 1'b1;
        gnt_idx_c = CH_W'(c);
        gnt_evt_c = '{ch: CH_W'(c), typ: pend_typ_q[c], pc: pend_pc_q[c]};
      end
    end
    if (full_c && !pop_c) gnt_vld_c = 1'b0;
  end

  // Pending capture / coalesce and sticky update
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_typ_d = pend_typ_q;
    pend_pc_d  = pend_pc_q;
    sticky_d   = sticky_q;
    n_coal     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_vld_c && (gnt_idx_c == CH_W'(i))) begin
        pend_vld_d[i] = |det_c[i];
        pend_typ_d[i] = det_c[i];
        pend_pc_d[i]  = ch_pc[i*PC_WIDTH +: PC_WIDTH];
      end else if (|det_c[i]) begin
        if (pend_vld_q[i]) begin
          pend_typ_d[i] = pend_typ_q[i] | det_c[i];
          n_coal        = n_coal + 5'd1;
        end else begin
          pend_vld_d[i] = 1'b1;
          pend_typ_d[i] = det_c[i];
          pend_pc_d[i]  = ch_pc[i*PC_WIDTH +: PC_WIDTH];
        end
      end
      sticky_d[i*4 +: 4] = (clear_sticky[i] ? 4'b0000 : sticky_q[i*4 +: 4]) | det_c[i];
    end
    coal_sum = {1'b0, coal_q} + 9'(n_coal);
    coal_d   = coal_sum[8] ? 8'hFF : coal_sum[7:0];
  end

  always_comb begin
    sev_d = 2'b00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sticky_q[i*4 + 3] && sev_d == 2'b00) sev_d = 2'b01;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if ((sticky_q[i*4 + 0] || sticky_q[i*4 + 1]) && sev_d != 2'b11) sev_d = 2'b10;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (sticky_q[i*4 + 2]) sev_d = 2'b11;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_vld_c && !pop_c) cnt_d = cnt_q + CNT_W'(1);
    else if (!gnt_vld_c && pop_c) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q  <= '0;
      pend_typ_q  <= '0;
      pend_pc_q   <= '0;
      priv_prev_q <= '0;
      flush_cnt_q <= '0;
      timer_q     <= '0;
      rr_q        <= '0;
      sticky_q    <= '0;
      coal_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      any_q       <= 1'b0;
      sev_q       <= 2'b00;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_typ_q  <= pend_typ_d;
      pend_pc_q   <= pend_pc_d;
      sticky_q    <= sticky_d;
      coal_q      <= coal_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= (cnt_d != '0);
      any_q       <= |sticky_q;
      sev_q       <= sev_d;
      timer_q     <= timer_wrap_c ? '0 : timer_q + TMR_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) priv_prev_q[i] <= ch_priv[i*PRIV_WIDTH +: PRIV_WIDTH];
        if (timer_wrap_c) flush_cnt_q[i] <= '0;
        else if (ch_flush[i] && (flush_cnt_q[i] < FC_W'(FLUSH_THRESH)))
          flush_cnt_q[i] <= flush_cnt_q[i] + FC_W'(1);
      end
      if (gnt_vld_c) begin
        mem_q[wr_ptr_q] <= gnt_evt_c;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
        rr_q            <= CH_W'((32'(gnt_idx_c) + 1) % NUM_CH);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_ch       = mem_q[rd_ptr_q].ch;
  assign evt_type     = mem_q[rd_ptr_q].typ;
  assign evt_pc       = mem_q[rd_ptr_q].pc;
  assign sticky       = sticky_q;
  assign any_anomaly  = any_q;
  assign severity     = sev_q;
  assign coalesce_cnt = coal_q;

endmodule

// File: tb/tb_kavach_exec_monitor_mc.sv
// Directed self-checking bench for kavach_exec_monitor_mc (default parameters).
module tb_kavach_exec_monitor_mc;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ch_valid, ch_exception, ch_mem_access, ch_flush, ch_mask, clear_sticky;
  logic [127:0] ch_pc, ch_pc_prev, ch_mem_addr;
  logic [7:0]   ch_priv;
  logic         evt_valid, evt_ready, any_anomaly;
  logic [3:0]   evt_ch, evt_type;
  logic [31:0]  evt_pc;
  logic [15:0]  sticky;
  logic [1:0]   severity;
  logic [7:0]   coalesce_cnt;
  int           n_tests = 0;
  int           n_fail  = 0;

  kavach_exec_monitor_mc dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_pc(ch_pc), .ch_pc_prev(ch_pc_prev),
    .ch_priv(ch_priv), .ch_exception(ch_exception), .ch_mem_access(ch_mem_access),
    .ch_mem_addr(ch_mem_addr), .ch_flush(ch_flush), .ch_mask(ch_mask),
    .clear_sticky(clear_sticky), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_type(evt_type), .evt_pc(evt_pc), .sticky(sticky),
    .any_anomaly(any_anomaly), .severity(severity), .coalesce_cnt(coalesce_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ch_valid = '0; ch_exception = '0; ch_mem_access = '0; ch_flush = '0;
    ch_mask = '0; clear_sticky = '0; ch_pc = '0; ch_pc_prev = '0;
    ch_mem_addr = '0; ch_priv = '0; evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic oob_all();
    for (int i = 0; i < 4; i++) begin
      ch_valid[i] = 1'b1;
      ch_mem_access[i] = 1'b1;
      ch_mem_addr[i*32 +: 32] = 32'h0000_1000;
      ch_pc[i*32 +: 32] = 32'(i + 1) * 32'h100;
      ch_pc_prev[i*32 +: 32] = 32'(i + 1) * 32'h100;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk("rst_evt_valid", 64'(evt_valid), 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
    chk("rst_severity", 64'(severity), 64'd0);
    chk("rst_coalesce", 64'(coalesce_cnt), 64'd0);
    chk("rst_any", 64'(any_anomaly), 64'd0);
    rst = 1'b0;

    // Channel 1 jump
    do_reset();
    ch_valid[1] = 1'b1;
    ch_pc_prev[63:32] = 32'h0000_1000;
    ch_pc[63:32] = 32'h0002_0000;
    tick();
    chk("jump_valid_n", 64'(evt_valid), 64'd0);
    chk("jump_sticky", 64'(sticky), 64'h0010);
    chk("jump_sev_n", 64'(severity), 64'd0);
    idle();
    tick();
    chk("jump_valid", 64'(evt_valid), 64'd1);
    chk("jump_ch", 64'(evt_ch), 64'd1);
    chk("jump_type", 64'(evt_type), 64'b0001);
    chk("jump_pc", 64'(evt_pc), 64'h2_0000);
    chk("jump_sev", 64'(severity), 64'b10);
    chk("jump_any", 64'(any_anomaly), 64'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("jump_popped", 64'(evt_valid), 64'd0);

    // Channel 0 privilege escalation
    do_reset();
    ch_valid[0] = 1'b1;
    ch_priv[1:0] = 2'b11;
    tick();
    chk("priv_sticky", 64'(sticky), 64'h0004);
    idle();
    tick();
    chk("priv_valid", 64'(evt_valid), 64'd1);
    chk("priv_ch", 64'(evt_ch), 64'd0);
    chk("priv_type", 64'(evt_type), 64'b0100);
    chk("priv_sev", 64'(severity), 64'b11);

    // Same transition during an exception
    do_reset();
    ch_valid[0] = 1'b1;
    ch_priv[1:0] = 2'b11;
    ch_exception[0] = 1'b1;
    tick();
    idle();
    tick();
    chk("privexc_valid", 64'(evt_valid), 64'd0);
    chk("privexc_sticky", 64'(sticky), 64'd0);

    // All channels out-of-bounds every cycle with backpressure
    do_reset();
    oob_all();
    tick();
    chk("oob_valid_e1", 64'(evt_valid), 64'd0);
    chk("oob_coal_e1", 64'(coalesce_cnt), 64'd0);
    chk("oob_sticky", 64'(sticky), 64'h2222);
    tick();
    chk("oob_valid_e2", 64'(evt_valid), 64'd1);
    chk("oob_head_e2", 64'(evt_ch), 64'd0);
    chk("oob_coal_e2", 64'(coalesce_cnt), 64'd3);
    repeat (7) tick();
    chk("oob_coal_full", 64'(coalesce_cnt), 64'd24);
    chk("oob_head_held", 64'(evt_ch), 64'd0);
    chk("oob_type", 64'(evt_type), 64'b0010);
    chk("oob_pc", 64'(evt_pc), 64'h100);
    tick();
    chk("oob_coal_blk", 64'(coalesce_cnt), 64'd28);
    chk("oob_sev", 64'(severity), 64'b10);
    repeat (60) tick();
    chk("oob_coal_sat", 64'(coalesce_cnt), 64'd255);
    chk("oob_still_valid", 64'(evt_valid), 64'd1);
    idle();
    evt_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("drain_valid_%0d", k), 64'(evt_valid), 64'd1);
      chk($sformatf("drain_ch_%0d", k), 64'(evt_ch), 64'(k % 4));
      chk($sformatf("drain_pc_%0d", k), 64'(evt_pc), 64'((k % 4 + 1) * 32'h100));
      chk($sformatf("drain_type_%0d", k), 64'(evt_type), 64'b0010);
      tick();
    end
    chk("drain_empty", 64'(evt_valid), 64'd0);
    chk("drain_coal_hold", 64'(coalesce_cnt), 64'd255);
    evt_ready = 1'b0;

    // Channel 2 flush burst
    do_reset();
    ch_flush[2] = 1'b1;
    repeat (7) tick();
    chk("flush7_sticky", 64'(sticky), 64'd0);
    chk("flush7_valid", 64'(evt_valid), 64'd0);
    tick();
    chk("flush8_sticky", 64'(sticky), 64'h0800);
    ch_flush[2] = 1'b0;
    tick();
    chk("flush_valid", 64'(evt_valid), 64'd1);
    chk("flush_ch", 64'(evt_ch), 64'd2);
    chk("flush_type", 64'(evt_type), 64'b1000);
    chk("flush_sev", 64'(severity), 64'b01);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("flush_popped", 64'(evt_valid), 64'd0);
    ch_flush[2] = 1'b1;
    tick();
    ch_flush[2] = 1'b0;
    tick();
    chk("flush9_none", 64'(evt_valid), 64'd0);

    // Sticky clear vs set on channel 3
    do_reset();
    ch_valid[3] = 1'b1;
    ch_pc[127:96] = 32'h0010_0000;
    clear_sticky[3] = 1'b1;
    tick();
    chk("clr_set_wins", 64'(sticky), 64'h1000);
    idle();
    clear_sticky[3] = 1'b1;
    tick();
    chk("clr_alone", 64'(sticky), 64'd0);
    chk("clr_any_lag", 64'(any_anomaly), 64'd1);
    idle();
    tick();
    chk("clr_any", 64'(any_anomaly), 64'd0);
    chk("clr_sev", 64'(severity), 64'd0);

    // Masked channel 1 jump
    do_reset();
    ch_mask[1] = 1'b1;
    ch_valid[1] = 1'b1;
    ch_pc[63:32] = 32'h0002_0000;
    tick();
    tick();
    chk("mask_valid", 64'(evt_valid), 64'd0);
    chk("mask_sticky", 64'(sticky), 64'd0);

    // Asynchronous reset with five queued entries
    do_reset();
    oob_all();
    repeat (6) tick();
    chk("mid_valid", 64'(evt_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(evt_valid), 64'd0);
    chk("mid_rst_coal", 64'(coalesce_cnt), 64'd0);
    chk("mid_rst_sticky", 64'(sticky), 64'd0);
    idle();
    tick();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
